// File: rtl/instr_dispatch_fsm.sv
// Instruction dispatcher: fetches ROM words, decodes them and hands
// MOV/ADD/SUB to the execution FSMs, waiting for done with a timeout.
module instr_dispatch_fsm #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [15:0]       instr_data,
    input  logic              fsm_done,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [3:0]        fsm_start,
    output logic [5:0]        source,
    output logic [5:0]        dest,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_MOV  = 4'b1010;
    localparam logic [3:0] OP_ADD  = 4'b1011;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_HALT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] ir_op;
    logic [7:0] count;
    logic [3:0] opcode;
    logic       raise_err;
    logic       timeout_hit;

    assign opcode      = instr_data[15:12];
    // count holds the number of WAIT cycles already elapsed
    assign timeout_hit = (count == 8'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fsm_start  = 4'b0000;
        busy       = 1'b1;
        halted     = 1'b0;
        raise_err  = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_MOV, OP_ADD, OP_SUB: state_next = S_ISSUE;
                    OP_NOP:                 state_next = S_ADVANCE;
                    OP_HALT:                state_next = S_HALT;
                    default: begin
                        raise_err  = 1'b1;
                        state_next = S_HALT;
                    end
                endcase
            end
            S_ISSUE: begin
                fsm_start  = ir_op;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (fsm_done) begin
                    state_next = S_ADVANCE;
                end else if (timeout_hit) begin
                    raise_err  = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_ADVANCE: begin
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_addr <= '0;
            ir_op      <= 4'b0000;
            source     <= 6'd0;
            dest       <= 6'd0;
            count      <= 8'd0;
            error      <= 1'b0;
        end else begin
            if (raise_err) begin
                error <= 1'b1;
            end
            if (state == S_DECODE) begin
                ir_op  <= opcode;
                source <= instr_data[11:6];
                dest   <= instr_data[5:0];
            end
            if (state == S_WAIT && state_next == S_WAIT) begin
                count <= count + 8'd1;
            end else begin
                count <= 8'd0;
            end
            if (state == S_ADVANCE) begin
                instr_addr <= instr_addr + ADDR_W'(1);
            end
        end
    end

endmodule
